// File: rtl/ara_xif_sequencer.sv
// XIF-side sequencer for Ara's instruction ring buffer: tracks live IDs in issue
// order and turns issue/register/commit/kill/pop traffic into buffer strobes.
module ara_xif_sequencer #(
    parameter int unsigned ID_WIDTH = 8,
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                issue_valid_i,
    input  logic [ID_WIDTH-1:0] issue_id_i,
    output logic                issue_ready_o,
    input  logic                reg_valid_i,
    input  logic [ID_WIDTH-1:0] reg_id_i,
    input  logic                commit_valid_i,
    input  logic [ID_WIDTH-1:0] commit_id_i,
    input  logic                commit_kill_i,
    input  logic                buf_pop_i,
    output logic                buf_push_o,
    output logic [ID_WIDTH-1:0] buf_id_o,
    output logic                buf_reg_valid_o,
    output logic [ID_WIDTH-1:0] buf_reg_id_o,
    output logic                buf_commit_o,
    output logic                buf_flush_o,
    output logic [ID_WIDTH-1:0] buf_commit_id_o,
    output logic [CNT_W-1:0]    outstanding_o,
    output logic                err_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_e;

    state_e              state_q;
    logic                active_q;
    logic [PTR_W-1:0]    head_q;
    logic [PTR_W-1:0]    tail_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [ID_WIDTH-1:0] id_q [DEPTH];
    logic [DEPTH-1:0]    reg_seen_q;
    logic [DEPTH-1:0]    committed_q;

    logic [DEPTH-1:0]    live;
    logic                issue_live, reg_hit, commit_hit, oldest_found;
    logic [PTR_W-1:0]    commit_slot, oldest_slot, head_d;
    logic                kill, issue_ready, issue_acc, reg_same, reg_ok;
    logic                commit_ok, flush, pop_ok, head_commit, head_reg, err;

    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input int off);
        int s;
        s = int'(p) + off;
        if (s >= int'(DEPTH)) s = s - int'(DEPTH);
        return PTR_W'(s);
    endfunction

    // Distance from b forward to a around the ring.
    function automatic logic [CNT_W-1:0] ptr_dist(input logic [PTR_W-1:0] a, input logic [PTR_W-1:0] b);
        int d;
        d = int'(a) - int'(b);
        if (d < 0) d = d + int'(DEPTH);
        return CNT_W'(d);
    endfunction

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        live         = '0;
        issue_live   = 1'b0;
        reg_hit      = 1'b0;
        commit_hit   = 1'b0;
        commit_slot  = '0;
        oldest_found = 1'b0;
        oldest_slot  = '0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            if (k < int'(cnt_q)) live[ptr_add(head_q, k)] = 1'b1;
        end
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (live[i] && id_q[i] == issue_id_i) issue_live = 1'b1;
            if (live[i] && id_q[i] == reg_id_i) reg_hit = 1'b1;
            if (live[i] && id_q[i] == commit_id_i) begin
                commit_hit  = 1'b1;
                commit_slot = PTR_W'(i);
            end
        end
        for (int k = 0; k < int'(DEPTH); k++) begin
            if (!oldest_found && k < int'(cnt_q) && !committed_q[ptr_add(head_q, k)]) begin
                oldest_found = 1'b1;
                oldest_slot  = ptr_add(head_q, k);
            end
        end
    end

    assign kill        = commit_valid_i & commit_kill_i;
    assign issue_ready = active_q & (state_q == RUN) & (cnt_q < CNT_W'(DEPTH)) & ~issue_live & ~kill;
    assign issue_acc   = issue_valid_i & issue_ready;
    assign reg_same    = issue_acc & reg_valid_i & (reg_id_i == issue_id_i);
    assign reg_ok      = active_q & reg_valid_i & (reg_hit | reg_same);
    assign commit_ok   = active_q & commit_valid_i & ~commit_kill_i & commit_hit
                       & oldest_found & (commit_slot == oldest_slot);
    assign flush       = active_q & kill & (state_q == RUN) & commit_hit & ~committed_q[commit_slot];
    assign pop_ok      = active_q & buf_pop_i & (cnt_q != '0);
    assign head_d      = pop_ok ? ptr_add(head_q, 1) : head_q;

    // A commit or register write landing on the head this cycle legalises a same-cycle pop.
    assign head_commit = committed_q[head_q] | (commit_ok & (commit_slot == head_q));
    assign head_reg    = reg_seen_q[head_q] | (reg_valid_i & (reg_id_i == id_q[head_q]));

    assign err = active_q & (
                   (reg_valid_i & ~reg_ok)
                 | (commit_valid_i & ~commit_kill_i & ~commit_ok)
                 | (kill & ~flush)
                 | (buf_pop_i & ((cnt_q == '0) | ~(head_commit & head_reg))));

    assign issue_ready_o   = issue_ready;
    assign buf_push_o      = issue_acc;
    assign buf_id_o        = issue_acc ? issue_id_i : '0;
    assign buf_reg_valid_o = reg_ok;
    assign buf_reg_id_o    = reg_ok ? reg_id_i : '0;
    assign buf_commit_o    = commit_ok;
    assign buf_flush_o     = flush;
    assign buf_commit_id_o = (commit_ok | flush) ? commit_id_i : '0;
    assign outstanding_o   = cnt_q;
    assign err_o           = err;

    // NOTE: queue storage is reset along with the pointers so no X ever reaches the ID compares.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= RUN;
            active_q    <= 1'b0;
            head_q      <= '0;
            tail_q      <= '0;
            cnt_q       <= '0;
            reg_seen_q  <= '0;
            committed_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) id_q[i] <= '0;
        end else begin
            active_q <= 1'b1;
            state_q  <= flush ? FLUSH : RUN;
            head_q   <= head_d;

            if (flush) begin
                if (pop_ok && commit_slot == head_q) begin
                    tail_q <= head_d;
                    cnt_q  <= '0;
                end else begin
                    tail_q <= commit_slot;
                    cnt_q  <= ptr_dist(commit_slot, head_d);
                end
            end else begin
                if (issue_acc) tail_q <= ptr_add(tail_q, 1);
                unique case ({issue_acc, pop_ok})
                    2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                    2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                    default: ;
                endcase
            end

            for (int i = 0; i < int'(DEPTH); i++) begin
                if (active_q && reg_valid_i && live[i] && id_q[i] == reg_id_i) reg_seen_q[i] <= 1'b1;
            end
            if (commit_ok) committed_q[commit_slot] <= 1'b1;
            if (issue_acc) begin
                id_q[tail_q]        <= issue_id_i;
                reg_seen_q[tail_q]  <= reg_same;
                committed_q[tail_q] <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ara_xif_sequencer.sv
// Directed bench for ara_xif_sequencer (DEPTH=2): stimulus queues expected buffer
// events, a negedge monitor pops and compares whenever the DUT emits a strobe.
module tb_ara_xif_sequencer;

    localparam int unsigned ID_WIDTH = 8;
    localparam int unsigned DEPTH    = 2;
    localparam int unsigned CNT_W    = $clog2(DEPTH + 1);

    typedef struct packed {
        logic       push;
        logic [7:0] id;
        logic       reg_v;
        logic [7:0] reg_id;
        logic       commit;
        logic       flush;
        logic [7:0] cid;
        logic       err;
    } ev_t;

    logic                clk_i = 1'b0;
    logic                rst_ni = 1'b0;
    logic                issue_valid_i = 1'b0;
    logic [ID_WIDTH-1:0] issue_id_i = '0;
    logic                issue_ready_o;
    logic                reg_valid_i = 1'b0;
    logic [ID_WIDTH-1:0] reg_id_i = '0;
    logic                commit_valid_i = 1'b0;
    logic [ID_WIDTH-1:0] commit_id_i = '0;
    logic                commit_kill_i = 1'b0;
    logic                buf_pop_i = 1'b0;
    logic                buf_push_o;
    logic [ID_WIDTH-1:0] buf_id_o;
    logic                buf_reg_valid_o;
    logic [ID_WIDTH-1:0] buf_reg_id_o;
    logic                buf_commit_o;
    logic                buf_flush_o;
    logic [ID_WIDTH-1:0] buf_commit_id_o;
    logic [CNT_W-1:0]    outstanding_o;
    logic                err_o;

    int    n_checks = 0;
    int    n_errors = 0;
    ev_t   exp_q[$];
    string name_q[$];
    ev_t   mon_act;
    ev_t   mon_exp;
    string mon_name;

    ara_xif_sequencer #(.ID_WIDTH(ID_WIDTH), .DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .issue_valid_i(issue_valid_i), .issue_id_i(issue_id_i), .issue_ready_o(issue_ready_o),
        .reg_valid_i(reg_valid_i), .reg_id_i(reg_id_i),
        .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i), .commit_kill_i(commit_kill_i),
        .buf_pop_i(buf_pop_i),
        .buf_push_o(buf_push_o), .buf_id_o(buf_id_o),
        .buf_reg_valid_o(buf_reg_valid_o), .buf_reg_id_o(buf_reg_id_o),
        .buf_commit_o(buf_commit_o), .buf_flush_o(buf_flush_o), .buf_commit_id_o(buf_commit_id_o),
        .outstanding_o(outstanding_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic ev_t ev(input logic push, input logic [7:0] id, input logic rv,
                               input logic [7:0] rid, input logic cm, input logic fl,
                               input logic [7:0] cid, input logic er);
        ev_t e;
        e = '{push: push, id: id, reg_v: rv, reg_id: rid, commit: cm, flush: fl, cid: cid, err: er};
        return e;
    endfunction

    always @(negedge clk_i) begin
        if (rst_ni && (buf_push_o || buf_reg_valid_o || buf_commit_o || buf_flush_o || err_o)) begin
            mon_act = ev(buf_push_o, buf_id_o, buf_reg_valid_o, buf_reg_id_o,
                         buf_commit_o, buf_flush_o, buf_commit_id_o, err_o);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_event: got %h, expected no event", mon_act);
            end else begin
                mon_exp  = exp_q.pop_front();
                mon_name = name_q.pop_front();
                check(mon_name, 64'(mon_act), 64'(mon_exp));
            end
        end
    end

    // One cycle of stimulus; optionally queues an expected event and checks issue_ready_o.
    task automatic drive(input string name,
                         input logic iv, input logic [7:0] iid,
                         input logic rv, input logic [7:0] rid,
                         input logic cv, input logic [7:0] cid, input logic ck,
                         input logic pop,
                         input logic has_exp, input ev_t e,
                         input logic chk_rdy, input logic exp_rdy);
        issue_valid_i  = iv;
        issue_id_i     = iid;
        reg_valid_i    = rv;
        reg_id_i       = rid;
        commit_valid_i = cv;
        commit_id_i    = cid;
        commit_kill_i  = ck;
        buf_pop_i      = pop;
        if (has_exp) begin
            exp_q.push_back(e);
            name_q.push_back(name);
        end
        #1;
        if (chk_rdy) check({name, "_ready"}, 64'(issue_ready_o), 64'(exp_rdy));
        @(negedge clk_i);
        @(posedge clk_i);
        #1;
        issue_valid_i  = 1'b0;
        issue_id_i     = '0;
        reg_valid_i    = 1'b0;
        reg_id_i       = '0;
        commit_valid_i = 1'b0;
        commit_id_i    = '0;
        commit_kill_i  = 1'b0;
        buf_pop_i      = 1'b0;
    endtask

    task automatic chk_out(input string name, input int exp);
        check(name, 64'(outstanding_o), 64'(exp));
    endtask

    localparam ev_t NO_EV = '0;

    initial begin
        // Reset with active inputs: everything must stay quiet.
        issue_valid_i = 1'b1;
        issue_id_i    = 8'd5;
        #12;
        check("rst_ready", 64'(issue_ready_o), 64'd0);
        check("rst_push", 64'(buf_push_o), 64'd0);
        check("rst_out", 64'(outstanding_o), 64'd0);
        issue_valid_i = 1'b0;
        issue_id_i    = '0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        check("ready_after_rst", 64'(issue_ready_o), 64'd1);

        drive("issue5", 1, 5, 0, 0, 0, 0, 0, 0, 1, ev(1, 5, 0, 0, 0, 0, 0, 0), 1, 1);
        chk_out("out_after_5", 1);
        drive("issue6", 1, 6, 0, 0, 0, 0, 0, 0, 1, ev(1, 6, 0, 0, 0, 0, 0, 0), 1, 1);
        chk_out("out_after_6", 2);
        check("full_ready", 64'(issue_ready_o), 64'd0);

        drive("reg5", 0, 0, 1, 5, 0, 0, 0, 0, 1, ev(0, 0, 1, 5, 0, 0, 0, 0), 0, 0);
        drive("commit5", 0, 0, 0, 0, 1, 5, 0, 0, 1, ev(0, 0, 0, 0, 1, 0, 5, 0), 0, 0);
        drive("full_issue_pop", 1, 7, 0, 0, 0, 0, 0, 1, 0, NO_EV, 1, 0);
        chk_out("out_after_pop5", 1);

        drive("dup6", 1, 6, 0, 0, 0, 0, 0, 0, 0, NO_EV, 1, 0);
        drive("issue7", 1, 7, 0, 0, 0, 0, 0, 0, 1, ev(1, 7, 0, 0, 0, 0, 0, 0), 1, 1);
        drive("dup7", 1, 7, 0, 0, 0, 0, 0, 0, 0, NO_EV, 1, 0);
        chk_out("out_live_6_7", 2);

        drive("ooo_commit7", 0, 0, 0, 0, 1, 7, 0, 0, 1, ev(0, 0, 0, 0, 0, 0, 0, 1), 0, 0);
        drive("reg_unknown9", 0, 0, 1, 9, 0, 0, 0, 0, 1, ev(0, 0, 0, 0, 0, 0, 0, 1), 0, 0);
        drive("reg6_commit6", 0, 0, 1, 6, 1, 6, 0, 0, 1, ev(0, 0, 1, 6, 1, 0, 6, 0), 0, 0);
        drive("commit7_pop6", 0, 0, 0, 0, 1, 7, 0, 1, 1, ev(0, 0, 0, 0, 1, 0, 7, 0), 0, 0);
        chk_out("out_after_pop6", 1);
        drive("pop7_noreg", 0, 0, 0, 0, 0, 0, 0, 1, 1, ev(0, 0, 0, 0, 0, 0, 0, 1), 0, 0);
        chk_out("out_after_pop7", 0);
        drive("pop_empty", 0, 0, 0, 0, 0, 0, 0, 1, 1, ev(0, 0, 0, 0, 0, 0, 0, 1), 0, 0);
        chk_out("out_no_underflow", 0);

        drive("issue3_reg3", 1, 3, 1, 3, 0, 0, 0, 0, 1, ev(1, 3, 1, 3, 0, 0, 0, 0), 1, 1);
        drive("issue4", 1, 4, 0, 0, 0, 0, 0, 0, 1, ev(1, 4, 0, 0, 0, 0, 0, 0), 1, 1);
        drive("commit3", 0, 0, 0, 0, 1, 3, 0, 0, 1, ev(0, 0, 0, 0, 1, 0, 3, 0), 0, 0);
        drive("pop3", 0, 0, 0, 0, 0, 0, 0, 1, 0, NO_EV, 0, 0);
        chk_out("out_after_pop3", 1);

        drive("issue1", 1, 1, 0, 0, 0, 0, 0, 0, 1, ev(1, 1, 0, 0, 0, 0, 0, 0), 1, 1);
        drive("kill1", 1, 9, 0, 0, 1, 1, 1, 0, 1, ev(0, 0, 0, 0, 0, 1, 1, 0), 1, 0);
        chk_out("out_after_kill1", 1);
        drive("flush_cycle_issue2", 1, 2, 0, 0, 0, 0, 0, 0, 0, NO_EV, 1, 0);
        drive("issue2_after_flush", 1, 2, 0, 0, 0, 0, 0, 0, 1, ev(1, 2, 0, 0, 0, 0, 0, 0), 1, 1);
        chk_out("out_after_issue2", 2);
        drive("kill2", 0, 0, 0, 0, 1, 2, 1, 0, 1, ev(0, 0, 0, 0, 0, 1, 2, 0), 0, 0);
        drive("kill_in_flush", 0, 0, 0, 0, 1, 4, 1, 0, 1, ev(0, 0, 0, 0, 0, 0, 0, 1), 0, 0);
        chk_out("out_kill_ignored", 1);
        drive("commit4", 0, 0, 0, 0, 1, 4, 0, 0, 1, ev(0, 0, 0, 0, 1, 0, 4, 0), 0, 0);
        drive("kill_committed4", 0, 0, 0, 0, 1, 4, 1, 0, 1, ev(0, 0, 0, 0, 0, 0, 0, 1), 0, 0);
        drive("kill_unknown99", 0, 0, 0, 0, 1, 99, 1, 0, 1, ev(0, 0, 0, 0, 0, 0, 0, 1), 0, 0);
        drive("reg4", 0, 0, 1, 4, 0, 0, 0, 0, 1, ev(0, 0, 1, 4, 0, 0, 0, 0), 0, 0);
        drive("pop4", 0, 0, 0, 0, 0, 0, 0, 1, 0, NO_EV, 0, 0);
        chk_out("out_after_pop4", 0);

        drive("issue10", 1, 10, 0, 0, 0, 0, 0, 0, 1, ev(1, 10, 0, 0, 0, 0, 0, 0), 1, 1);
        drive("issue11", 1, 11, 0, 0, 0, 0, 0, 0, 1, ev(1, 11, 0, 0, 0, 0, 0, 0), 1, 1);
        drive("kill10_pop", 0, 0, 0, 0, 1, 10, 1, 1, 1, ev(0, 0, 0, 0, 0, 1, 10, 1), 0, 0);
        chk_out("out_kill_head_pop", 0);
        drive("idle_flush", 0, 0, 0, 0, 0, 0, 0, 0, 0, NO_EV, 1, 0);

        for (int i = 0; i < 10; i++) begin
            drive("wrap_issue", 1, 8'(20 + i), 1, 8'(20 + i), 0, 0, 0, 0, 1,
                  ev(1, 8'(20 + i), 1, 8'(20 + i), 0, 0, 0, 0), 1, 1);
            drive("wrap_commit_pop", 0, 0, 0, 0, 1, 8'(20 + i), 0, 1, 1,
                  ev(0, 0, 0, 0, 1, 0, 8'(20 + i), 0), 0, 0);
        end
        chk_out("out_after_wrap", 0);

        drive("issue50", 1, 50, 0, 0, 0, 0, 0, 0, 1, ev(1, 50, 0, 0, 0, 0, 0, 0), 1, 1);
        drive("kill50", 0, 0, 0, 0, 1, 50, 1, 0, 1, ev(0, 0, 0, 0, 0, 1, 50, 0), 0, 0);

        // Reset in the FLUSH cycle with every input active.
        rst_ni         = 1'b0;
        issue_valid_i  = 1'b1;
        issue_id_i     = 8'd60;
        reg_valid_i    = 1'b1;
        reg_id_i       = 8'd61;
        commit_valid_i = 1'b1;
        commit_id_i    = 8'd62;
        commit_kill_i  = 1'b1;
        buf_pop_i      = 1'b1;
        #1;
        check("midrst_outs", 64'({issue_ready_o, buf_push_o, buf_id_o, buf_reg_valid_o, buf_reg_id_o,
                                  buf_commit_o, buf_flush_o, buf_commit_id_o, err_o}), 64'd0);
        check("midrst_out", 64'(outstanding_o), 64'd0);
        issue_valid_i  = 1'b0;
        issue_id_i     = '0;
        reg_valid_i    = 1'b0;
        reg_id_i       = '0;
        commit_valid_i = 1'b0;
        commit_id_i    = '0;
        commit_kill_i  = 1'b0;
        buf_pop_i      = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        check("ready_after_midrst", 64'(issue_ready_o), 64'd1);
        drive("issue50_again", 1, 50, 0, 0, 0, 0, 0, 0, 1, ev(1, 50, 0, 0, 0, 0, 0, 0), 1, 1);
        chk_out("out_after_midrst", 1);

        @(negedge clk_i);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
